// File: rtl/masked_sbox_iter.sv
// Iterated threshold-implementation S-box core: ROUNDS applications of the
// 3-share nonlinear step G with a per-share rotate between rounds.
// Optional build macro SBOX_ITER_REMASK_EN adds the rnd port and re-masks
// shares 2 and 3 on every state-register load.
module masked_sbox_iter #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] x1,
  input  logic [3:0] x2,
  input  logic [3:0] x3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic [3:0] y3,
  output logic       busy
`ifdef SBOX_ITER_REMASK_EN
  ,
  input  logic [3:0] rnd
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ROUNDS_L  = 4'(ROUNDS);
  localparam logic       ONE_ROUND = (ROUNDS == 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] s1_q, s2_q, s3_q;
  logic [3:0] s1_d, s2_d, s3_d;

  logic       accept;
  logic       last;
  logic [3:0] v1, v2, v3;
  logic [3:0] g1, g2, g3;
  logic [3:0] n1, n2, n3;
  logic [3:0] mask;

  // Share i of G only sees input shares i and i+1, keeping the step
  // non-complete; the XOR of the three t terms equals a&b.
  function automatic logic [3:0] g_share(input logic [3:0] vi,
                                         input logic [3:0] vj,
                                         input logic       inv);
    logic ai, bi, aj, bj, t;
    ai = vi[3];
    bi = vi[2];
    aj = vj[3];
    bj = vj[2];
    t  = (ai & bi) ^ (ai & bj) ^ (aj & bi);
    return {vi[3:1], vi[0] ^ ai ^ bi ^ t ^ inv};
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign y1        = s1_q;
  assign y2        = s2_q;
  assign y3        = s3_q;

  assign accept = in_valid && in_ready;

`ifdef SBOX_ITER_REMASK_EN
  assign mask = rnd;
`else
  assign mask = '0;
`endif

  always_comb begin
    v1 = s1_q;
    v2 = s2_q;
    v3 = s3_q;
    if (state_q != RUN) begin
      v1 = x1;
      v2 = x2;
      v3 = x3;
    end

    g1 = g_share(v1, v2, 1'b1);
    g2 = g_share(v2, v3, 1'b0);
    g3 = g_share(v3, v1, 1'b0);

    if (state_q == RUN) begin
      last = (({1'b0, cnt_q} + 4'd1) == ROUNDS_L);
    end else begin
      last = ONE_ROUND;
    end

    n1 = last ? g1 : rotl(g1);
    n2 = (last ? g2 : rotl(g2)) ^ mask;
    n3 = (last ? g3 : rotl(g3)) ^ mask;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          s1_d    = n1;
          s2_d    = n2;
          s3_d    = n3;
          cnt_d   = 3'd1;
          state_d = ONE_ROUND ? DONE : RUN;
        end
      end
      RUN: begin
        s1_d = n1;
        s2_d = n2;
        s3_d = n3;
        // Counter holds on the final round so ROUNDS=8 never wraps to 0.
        if (last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            s1_d    = n1;
            s2_d    = n2;
            s3_d    = n3;
            cnt_d   = 3'd1;
            state_d = ONE_ROUND ? DONE : RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
    end
  end

endmodule

// File: tb/tb_masked_sbox_iter.sv
// Directed bench for masked_sbox_iter with ROUNDS=4; also drives rnd when
// built with SBOX_ITER_REMASK_EN.
module tb_masked_sbox_iter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x1, x2, x3;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y1, y2, y3;
  logic       busy;
`ifdef SBOX_ITER_REMASK_EN
  logic [3:0] rnd;
`endif

  int checks;
  int errors;

  masked_sbox_iter #(.ROUNDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .busy      (busy)
`ifdef SBOX_ITER_REMASK_EN
    ,
    .rnd       (rnd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SBOX_ITER_REMASK_EN
  initial rnd = 4'h0;
  always @(negedge clk) rnd = 4'($urandom);
`endif

  // Unshared reference: 4 rounds of g with a rotate between rounds.
  function automatic logic [3:0] model(input logic [3:0] x);
    logic [3:0] v;
    v = x;
    for (int r = 1; r <= 4; r++) begin
      v[0] = v[0] ^ ~(v[3] | v[2]);
      if (r < 4) v = {v[2:0], v[3]};
    end
    return v;
  endfunction

  // Drive one randomly-shared nibble; assumes in_ready, returns #1 after the
  // accepting edge with in_valid dropped.
  task automatic send(input logic [3:0] x);
    logic [3:0] r1, r2;
    r1 = 4'($urandom);
    r2 = 4'($urandom);
    x1 = r1;
    x2 = r2;
    x3 = x ^ r1 ^ r2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b required 0 0 1",
               out_valid, busy, in_ready);
    end
    checks++;
    if ({y1, y2, y3} !== 12'h000) begin
      errors++;
      $display("FAIL reset_y: y=%h %h %h required 0 0 0", y1, y2, y3);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int cyc;
    out_ready = 1'b1;
    x1 = 4'h5;
    x2 = 4'hA;
    x3 = 4'hF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_run: busy=%b in_ready=%b out_valid=%b required 1 0 0",
               busy, in_ready, out_valid);
    end
    wait_out(cyc);
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles required 3", cyc);
    end
    checks++;
    if ((y1 ^ y2 ^ y3) !== 4'hC) begin
      errors++;
      $display("FAIL basic_value: got %h required c", y1 ^ y2 ^ y3);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_ready: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_values;
    logic [3:0] xs [2];
    logic [3:0] ex [2];
    int cyc;
    xs[0] = 4'hF; ex[0] = 4'hF;
    xs[1] = 4'h1; ex[1] = 4'h6;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(xs[i]);
      wait_out(cyc);
      checks++;
      if (out_valid !== 1'b1 || (y1 ^ y2 ^ y3) !== ex[i]) begin
        errors++;
        $display("FAIL value_x%h: valid=%b got %h required %h",
                 xs[i], out_valid, y1 ^ y2 ^ y3, ex[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] h1, h2, h3;
    logic [3:0] r1, r2;
    int cyc;
    out_ready = 1'b0;
    send(4'h0);
    wait_out(cyc);
    h1 = y1;
    h2 = y2;
    h3 = y3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {y1, y2, y3} !== {h1, h2, h3}) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b in_ready=%b y=%h%h%h required 1 0 %h%h%h",
                 i, out_valid, in_ready, y1, y2, y3, h1, h2, h3);
      end
    end
    checks++;
    if ((h1 ^ h2 ^ h3) !== 4'hC) begin
      errors++;
      $display("FAIL hold_value: got %h required c", h1 ^ h2 ^ h3);
    end
    r1 = 4'($urandom);
    r2 = 4'($urandom);
    x1 = r1;
    x2 = r2;
    x3 = 4'h1 ^ r1 ^ r2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_capture: busy=%b out_valid=%b required 1 0", busy, out_valid);
    end
    wait_out(cyc);
    checks++;
    if (cyc != 3 || (y1 ^ y2 ^ y3) !== 4'h6) begin
      errors++;
      $display("FAIL b2b_value: cycles=%0d got %h required 3 cycles value 6",
               cyc, y1 ^ y2 ^ y3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_run_ignore;
    int cyc;
    out_ready = 1'b1;
    send(4'h0);
    x1 = 4'hF;
    x2 = 4'h0;
    x3 = 4'h0;
    in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_out(cyc);
    checks++;
    if (cyc != 1 || (y1 ^ y2 ^ y3) !== 4'hC) begin
      errors++;
      $display("FAIL run_ignore: cycles=%0d got %h required 1 cycle value c",
               cyc, y1 ^ y2 ^ y3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int cyc;
    out_ready = 1'b1;
    send(4'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {y1, y2, y3} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: busy=%b valid=%b in_ready=%b y=%h%h%h required 0 0 1 000",
               busy, out_valid, in_ready, y1, y2, y3);
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
    send(4'h0);
    wait_out(cyc);
    checks++;
    if (cyc != 3 || (y1 ^ y2 ^ y3) !== 4'hC) begin
      errors++;
      $display("FAIL reset_recover: cycles=%0d got %h required 3 cycles value c",
               cyc, y1 ^ y2 ^ y3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep;
    int cyc;
    logic [3:0] ex;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int v = 0; v < 16; v++) begin
        ex = model(4'(v));
        send(4'(v));
        wait_out(cyc);
        checks++;
        if (cyc != 3 || (y1 ^ y2 ^ y3) !== ex) begin
          errors++;
          $display("FAIL sweep_x%h: cycles=%0d got %h required 3 cycles value %h",
                   4'(v), cyc, y1 ^ y2 ^ y3, ex);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x1 = 4'h0;
    x2 = 4'h0;
    x3 = 4'h0;
    test_reset;
    test_basic;
    test_values;
    test_backpressure;
    test_run_ignore;
    test_reset_mid;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/masked_sbox_iter.md
MASKED_SBOX_ITER -- requirements
Module: masked_sbox_iter

Interface
REQ-001 SHALL have parameter: ROUNDS, default 4, number of nonlinear iterations per S-box evaluation (legal 1..8).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input shares valid.
- in_ready  out  1  block can accept input.
- x1, x2, x3  in  4 each  Boolean shares of input nibble; x = x1^x2^x3.
- out_valid  out  1  output shares valid.
- out_ready  in  1  downstream (affine layer) accepts output.
- y1, y2, y3  out  4 each  registered output shares; y = y1^y2^y3.
- busy  out  1  high in RUN.
- rnd  in  4  fresh mask; present only with SBOX_ITER_REMASK_EN.

Function
REQ-003 SHALL define G on 3 shares (v_i, i=1..3, indices mod 3): a_i=v_i[3], b_i=v_i[2]; t_i = a_i&b_i ^ a_i&b_(i+1) ^ a_(i+1)&b_i.
REQ-004 SHALL set G output share i = v_i with bit0 replaced by v_i[0]^a_i^b_i^t_i, with share 1 bit0 additionally inverted; bits 3..1 unchanged.
REQ-005 Unshared result SHALL equal g(v) = v with bit0 ^= ~(v3|v2).
REQ-006 Each output share of G SHALL depend on at most two input share indices (non-completeness); no cross-share logic outside G.
REQ-007 Between rounds the state SHALL rotate left by one bit per share ({v[2:0],v[3]}); no rotation after the final round.
REQ-008 SHALL implement FSM states IDLE, RUN, DONE; one round of G (plus rotation) per cycle into a 3x4-bit share state register.
REQ-009 IDLE: in_ready=1; on in_valid SHALL capture G(x) (plus rotation if ROUNDS>1), load round counter =1, go to RUN (ROUNDS>1) or DONE (ROUNDS=1).
REQ-010 RUN: in_ready=0, busy=1; counter increments per cycle; on the cycle applying round ROUNDS SHALL go to DONE.
REQ-011 DONE: out_valid=1, y1..y3 = state; outputs SHALL remain stable while out_valid && !out_ready.
REQ-012 DONE with out_ready=1: in_ready=1; simultaneous in_valid SHALL capture the new input and go to RUN/DONE same cycle (back-to-back); otherwise go to IDLE.
REQ-013 Latency: input accepted at edge N, out_valid high after edge N+ROUNDS-1.
REQ-014 in_valid while in RUN SHALL be ignored (in_ready=0); data not captured.
REQ-015 Round counter width 3 bits; SHALL NOT wrap within an evaluation.

Reset
REQ-016 rst_n=0 at an edge SHALL force IDLE, counter=0, state and y1..y3=0, out_valid=0, busy=0, in_ready=1 after that edge, including mid-RUN (evaluation aborted, no output).
REQ-017 Combinational outputs SHALL derive from FSM state only; no async reset paths.

Configuration
REQ-018 Macro SBOX_ITER_REMASK_EN defined: rnd port exists; each state-register load SHALL XOR rnd into shares 2 and 3 (unshared value unchanged).
REQ-019 Macro undefined: no rnd port; state loads are G output only; unshared behaviour identical in both builds.

Verification
REQ-020 x=0x0 as shares (0x5,0xA,0xF), ROUNDS=4, out_ready=1 -> out_valid 3 cycles after accept, y1^y2^y3=0xC.
REQ-021 x=0xF and x=0x1 (random sharing) -> unshared outputs 0xF and 0x6 respectively.
REQ-022 out_ready=0 for 5 cycles in DONE -> y1..y3 and out_valid stable, in_ready=0; release with in_valid=1 x=0x1 -> new capture same edge, next out 0x6.
REQ-023 rst_n=0 during round 2 -> next cycle IDLE, all outputs 0, in_ready=1; following x=0x0 yields 0xC.
REQ-024 SBOX_ITER_REMASK_EN with random rnd each cycle, all 16 x over 1000 random sharings -> unshared outputs match non-remask build; shares differ.
